// File: rtl/triangle_pkg.sv
// triangle_pkg: default triangle geometry, coordinate/vertex/triangle types and flat-width helper.
package triangle_pkg;
  localparam int DEF_WI = 2;
  localparam int DEF_WF = 2;
  localparam int DEF_VERTS = 3;
  localparam int DEF_COORDS = 3;
  typedef logic [DEF_WI+DEF_WF-1:0] coord_t;
  typedef coord_t [DEF_COORDS-1:0] vertex_t;
  typedef vertex_t [DEF_VERTS-1:0] tri_t;
  function automatic int tri_bits(int wi, int wf, int verts, int coords);
    return verts * coords * (wi + wf);
  endfunction
endpackage

// File: rtl/triangle_stream_fifo_if.sv
// triangle_stream_fifo_if: producer/consumer triangle stream handshakes; master drives, slave is the FIFO.
interface triangle_stream_fifo_if
  import triangle_pkg::*;
#(
  parameter int WI = DEF_WI,
  parameter int WF = DEF_WF,
  parameter int VERTS = DEF_VERTS,
  parameter int COORDS = DEF_COORDS
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [VERTS-1:0][COORDS-1:0][WI+WF-1:0] in_tri, out_tri;
  modport master(output in_valid, in_tri, out_ready, input in_ready, out_valid, out_tri);
  modport slave(input in_valid, in_tri, out_ready, output in_ready, out_valid, out_tri);
endinterface

// File: rtl/triangle_fifo_ram.sv
// triangle_fifo_ram: unreset triangle storage, one synchronous write port, asynchronous read port.
module triangle_fifo_ram #(
  parameter int W = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/triangle_stream_fifo.sv
// triangle_stream_fifo: FWFT triangle FIFO with status and flush.
// Define TRIANGLE_FIFO_BYPASS_EN for zero-latency pass-through when empty.
module triangle_stream_fifo
  import triangle_pkg::*;
#(
  parameter int WI = DEF_WI,
  parameter int WF = DEF_WF,
  parameter int VERTS = DEF_VERTS,
  parameter int COORDS = DEF_COORDS,
  parameter int DEPTH = 4,
  parameter int AF_THRESH = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     flush,
  triangle_stream_fifo_if.slave    s,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     is_empty,
  output logic                     is_full,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = tri_bits(WI, WF, VERTS, COORDS);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop, byp;
  logic [TW-1:0] rd_data;
  triangle_fifo_ram #(.W(TW), .DEPTH(DEPTH)) u_ram (
    .clk(Clk), .we(push), .waddr(wr_ptr_q), .wdata(s.in_tri), .raddr(rd_ptr_q), .rdata(rd_data)
  );
  always_comb begin
    is_empty = count_q == '0;
    is_full = count_q == CW'(DEPTH);
    almost_full = count_q >= CW'(AF_THRESH);
`ifdef TRIANGLE_FIFO_BYPASS_EN
    byp = is_empty & s.in_valid & s.out_ready & !flush;
`else
    byp = 1'b0;
`endif
    s.in_ready = !is_full & !flush;
    s.out_valid = (!is_empty & !flush) | byp;
    s.out_tri = byp ? s.in_tri : rd_data;
    // a bypassed triangle is consumed directly, so it neither writes nor counts
    push = s.in_valid & s.in_ready & !byp;
    pop = !is_empty & !flush & s.out_ready;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  assign count = count_q;
endmodule

// File: tb/tb_triangle_stream_fifo.sv
// tb_triangle_stream_fifo: queue-model scoreboard bench, directed corner cases then random traffic.
module tb_triangle_stream_fifo;
  import triangle_pkg::*;
  localparam int DEPTH = 4;
  localparam int AF = 3;
`ifdef TRIANGLE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic Clk = 1'b0, Reset = 1'b0, flush = 1'b0;
  logic [2:0] count;
  logic is_empty, is_full, almost_full;
  int n_chk = 0, n_pass = 0;
  int mcount = 0;
  bit exp_ov = 1'b0;
  tri_t sb[$];
  triangle_stream_fifo_if #(.WI(2), .WF(2), .VERTS(3), .COORDS(3)) bus ();
  triangle_stream_fifo #(.WI(2), .WF(2), .VERTS(3), .COORDS(3), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .Clk(Clk), .Reset(Reset), .flush(flush), .s(bus),
    .count(count), .is_empty(is_empty), .is_full(is_full), .almost_full(almost_full)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask
  function automatic tri_t fill(input logic [3:0] c);
    tri_t t;
    for (int v = 0; v < 3; v++) for (int k = 0; k < 3; k++) t[v][k] = c;
    return t;
  endfunction
  // expected values come from the queue model maintained by the stimulus
  always @(negedge Clk) if (Reset) begin
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    chk("count", 64'(count), 64'(mcount));
    chk("is_empty", 64'(is_empty), 64'(mcount == 0));
    chk("is_full", 64'(is_full), 64'(mcount == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(mcount >= AF));
    chk("in_ready", 64'(bus.in_ready), 64'(mcount < DEPTH && !flush));
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("pop_nonempty", 64'(0), 64'(1));
      else chk("out_tri", 64'(bus.out_tri), 64'(sb.pop_front()));
    end
  end
  task automatic step(input bit v, input bit r, input bit f, input tri_t d);
    bit byp, acc, pp;
    byp = BYP && mcount == 0 && v && r && !f;
    acc = v && mcount < DEPTH && !f && !byp;
    pp = mcount > 0 && r && !f;
    exp_ov = (mcount > 0 && !f) || byp;
    if (byp || acc) sb.push_back(d);
    bus.in_valid = v;
    bus.out_ready = r;
    bus.in_tri = d;
    flush = f;
    @(posedge Clk);
    #1;
    if (f) begin
      mcount = 0;
      sb.delete();
    end else mcount = mcount + int'(acc) - int'(pp);
  endtask
  task automatic async_reset();
    Reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(is_empty), 64'(1));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_full", 64'(is_full), 64'(0));
    chk("rst_af", 64'(almost_full), 64'(0));
    mcount = 0;
    sb.delete();
    exp_ov = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_tri = '0;
    async_reset();
    step(1, 0, 0, fill(4'h7));
    step(1, 0, 0, fill(4'h8));
    async_reset();
    step(1, 0, 0, fill(4'h1));
    step(1, 0, 0, fill(4'h3));
    step(1, 0, 0, fill(4'hC));
    step(1, 0, 0, fill(4'hF));
    step(1, 0, 0, fill(4'h5));
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(1, 0, 0, fill(4'hA));
    step(1, 0, 0, fill(4'hB));
    for (int i = 0; i < 6; i++) step(1, 1, 0, fill(4'(i)));
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, fill(4'(i + 9)));
    step(1, 1, 1, fill(4'hE));
    step(0, 0, 0, '0);
    step(1, 1, 0, fill(4'h5));
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0, tri_t'({$urandom(), $urandom()}));
    step(0, 0, 0, '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
